partition_drain: RTL

Downstream stage of `partition`: drains the info FIFO (one descriptor per partition) and the data FIFO (payload words) that `partition` fills. Re-emits each partition as a framed AXI4-Stream packet on the C2H datapath: one header beat followed by the payload beats. Signals `process_done` back to `partition` once the partition flagged final has fully left the block.

---
 rtl/partition_pkg.sv | 40 ++++
 rtl/axis_out_reg.sv | 54 +++++
 rtl/partition_drain.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/partition_pkg.sv
// partition_pkg: layout shared by partition (producer) and partition_drain
// (consumer) so both sides agree on the info FIFO descriptor format.
//   Descriptor word: [15:0]  N  payload beats
//                    [23:16] partition id
//                    [28:24] B  valid bytes in last payload beat (0 means full)
//                    [31]    F  final partition flag
//                    others  reserved, carried through in the header beat
package partition_pkg;

    localparam int DESC_N_LSB  = 0;
    localparam int DESC_N_W    = 16;
    localparam int DESC_ID_LSB = 16;
    localparam int DESC_ID_W   = 8;
    localparam int DESC_B_LSB  = 24;
    localparam int DESC_B_W    = 5;
    localparam int DESC_F_BIT  = 31;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2
    } drain_state_e;

    // Builds a descriptor word; used by the producer side.
    function automatic logic [31:0] make_desc(
        input logic [DESC_N_W-1:0]  beats,
        input logic [DESC_ID_W-1:0] id,
        input logic [DESC_B_W-1:0]  bytes,
        input logic                 final_f
    );
        logic [31:0] w;
        w = 32'd0;
        w[DESC_N_LSB  +: DESC_N_W]  = beats;
        w[DESC_ID_LSB +: DESC_ID_W] = id;
        w[DESC_B_LSB  +: DESC_B_W]  = bytes;
        w[DESC_F_BIT]               = final_f;
        return w;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// axis_out_reg: one-entry AXI4-Stream output register.
//   clk/rst          clock, synchronous active-high reset
//   load, load_*     write a new beat (only when free is high)
//   free             register empty or its beat is being accepted this cycle
//   tdata/tkeep/tlast/tvalid/tready  registered stream output
module axis_out_reg #(
    parameter int DATA_WIDTH = 128,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [KEEP_WIDTH-1:0] load_keep,
    input  logic                  load_last,
    output logic                  free,
    output logic [DATA_WIDTH-1:0] tdata,
    output logic [KEEP_WIDTH-1:0] tkeep,
    output logic                  tlast,
    output logic                  tvalid,
    input  logic                  tready
);

    logic [DATA_WIDTH-1:0] data_r;
    logic [KEEP_WIDTH-1:0] keep_r;
    logic                  last_r;
    logic                  valid_r;

    assign free   = ~valid_r | tready;
    assign tdata  = data_r;
    assign tkeep  = keep_r;
    assign tlast  = last_r;
    assign tvalid = valid_r;

    // Beat storage: load wins, otherwise drop valid once the sink takes the beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r  <= {DATA_WIDTH{1'b0}};
            keep_r  <= {KEEP_WIDTH{1'b0}};
            last_r  <= 1'b0;
            valid_r <= 1'b0;
        end else if (load) begin
            data_r  <= load_data;
            keep_r  <= load_keep;
            last_r  <= load_last;
            valid_r <= 1'b1;
        end else if (tready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

endmodule

// File: rtl/partition_drain.sv
// partition_drain: drains the info FIFO (one descriptor per partition) and the
// data FIFO (payload words) and re-emits each partition as an AXI4-Stream
// packet: one header beat (zero-extended descriptor) then N payload beats.
//   user_clk/user_rst            clock, synchronous active-high reset
//   info_fifo_*                  FWFT descriptor FIFO, pop via info_fifo_rd_en
//   data_fifo_*                  FWFT payload FIFO, pop via data_fifo_rd_en
//   m_axis_c2h_*                 registered stream output
//   process_done                 one-cycle pulse after final partition leaves
//   partition_count              partitions sent since reset (wraps)
module partition_drain
    import partition_pkg::*;
#(
    parameter int DATA_WIDTH      = 128,
    parameter int BYTE_BIT_ENABLE = DATA_WIDTH / 8,
    parameter int INFO_WIDTH      = 32
) (
    input  logic                       user_clk,
    input  logic                       user_rst,
    input  logic [INFO_WIDTH-1:0]      info_fifo_dout,
    input  logic                       info_fifo_empty,
    output logic                       info_fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]      data_fifo_dout,
    input  logic                       data_fifo_empty,
    output logic                       data_fifo_rd_en,
    output logic [DATA_WIDTH-1:0]      m_axis_c2h_tdata,
    output logic [BYTE_BIT_ENABLE-1:0] m_axis_c2h_tkeep,
    output logic                       m_axis_c2h_tlast,
    output logic                       m_axis_c2h_tvalid,
    input  logic                       m_axis_c2h_tready,
    output logic                       process_done,
    output logic [15:0]                partition_count
);

    // Byte enables for the last payload beat: B low bytes, B==0 means full.
    function automatic logic [BYTE_BIT_ENABLE-1:0] last_keep(input logic [DESC_B_W-1:0] b);
        logic [BYTE_BIT_ENABLE-1:0] k;
        for (int i = 0; i < BYTE_BIT_ENABLE; i++) begin
            k[i] = (b == 5'd0) || (i < int'(b));
        end
        return k;
    endfunction

    drain_state_e              state_r, next_state_s, hold_state_s;
    logic [DESC_N_W-1:0]       beats_r, next_beats_s;
    logic [DESC_B_W-1:0]       bytes_r;
    logic                      final_r;
    logic [15:0]               count_r;
    logic                      done_r;

    logic                       idle_start_s, start_s, finish_s, pop_data_s;
    logic                       out_free_s, out_accept_s;
    logic                       load_s, load_last_s;
    logic [DATA_WIDTH-1:0]      load_data_s;
    logic [BYTE_BIT_ENABLE-1:0] load_keep_s;

    assign out_accept_s    = m_axis_c2h_tvalid & m_axis_c2h_tready;
    assign info_fifo_rd_en = start_s & ~user_rst;
    assign data_fifo_rd_en = pop_data_s & ~user_rst;
    assign process_done    = done_r;
    assign partition_count = count_r;

    // Next-state, FIFO pop and output-register load decisions.
    always_comb begin
        idle_start_s = 1'b0;
        finish_s     = 1'b0;
        pop_data_s   = 1'b0;
        hold_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                idle_start_s = ~info_fifo_empty & out_free_s;
            end
            ST_HEADER: begin
                if (out_accept_s) begin
                    if (beats_r == 16'd0) begin
                        finish_s = 1'b1;
                    end else begin
                        // Header leaving frees the register, so the first word can follow at once.
                        hold_state_s = ST_DATA;
                        pop_data_s   = ~data_fifo_empty;
                    end
                end else begin
                    hold_state_s = ST_HEADER;
                end
            end
            ST_DATA: begin
                if (beats_r != 16'd0) begin
                    pop_data_s = ~data_fifo_empty & out_free_s;
                end else begin
                    // All words popped; wait for the last beat to be taken.
                    finish_s = out_accept_s & m_axis_c2h_tlast;
                end
            end
            default: begin
                hold_state_s = ST_IDLE;
            end
        endcase

        // A finishing partition may hand straight over to the next descriptor.
        start_s = idle_start_s | (finish_s & ~info_fifo_empty);

        if (start_s) begin
            next_state_s = ST_HEADER;
            next_beats_s = info_fifo_dout[DESC_N_LSB +: DESC_N_W];
        end else if (finish_s) begin
            next_state_s = ST_IDLE;
            next_beats_s = beats_r;
        end else if (pop_data_s) begin
            next_state_s = ST_DATA;
            next_beats_s = beats_r - 16'd1;
        end else begin
            next_state_s = hold_state_s;
            next_beats_s = beats_r;
        end

        if (start_s) begin
            load_s      = 1'b1;
            load_data_s = {{(DATA_WIDTH-INFO_WIDTH){1'b0}}, info_fifo_dout};
            load_keep_s = {BYTE_BIT_ENABLE{1'b1}};
            load_last_s = (info_fifo_dout[DESC_N_LSB +: DESC_N_W] == 16'd0);
        end else if (pop_data_s) begin
            load_s      = 1'b1;
            load_data_s = data_fifo_dout;
            load_last_s = (beats_r == 16'd1);
            load_keep_s = (beats_r == 16'd1) ? last_keep(bytes_r) : {BYTE_BIT_ENABLE{1'b1}};
        end else begin
            load_s      = 1'b0;
            load_data_s = {DATA_WIDTH{1'b0}};
            load_keep_s = {BYTE_BIT_ENABLE{1'b0}};
            load_last_s = 1'b0;
        end
    end

    // FSM state, per-partition latches, partition counter and done pulse.
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state_r <= ST_IDLE;
            beats_r <= 16'd0;
            bytes_r <= 5'd0;
            final_r <= 1'b0;
            count_r <= 16'd0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            beats_r <= next_beats_s;
            if (start_s) begin
                bytes_r <= info_fifo_dout[DESC_B_LSB +: DESC_B_W];
                final_r <= info_fifo_dout[DESC_F_BIT];
            end else begin
                bytes_r <= bytes_r;
                final_r <= final_r;
            end
            if (finish_s) begin
                count_r <= count_r + 16'd1;
            end else begin
                count_r <= count_r;
            end
            // final_r still belongs to the finishing partition on this edge.
            done_r <= finish_s & final_r;
        end
    end

    axis_out_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .KEEP_WIDTH (BYTE_BIT_ENABLE)
    ) u_out (
        .clk       (user_clk),
        .rst       (user_rst),
        .load      (load_s),
        .load_data (load_data_s),
        .load_keep (load_keep_s),
        .load_last (load_last_s),
        .free      (out_free_s),
        .tdata     (m_axis_c2h_tdata),
        .tkeep     (m_axis_c2h_tkeep),
        .tlast     (m_axis_c2h_tlast),
        .tvalid    (m_axis_c2h_tvalid),
        .tready    (m_axis_c2h_tready)
    );

endmodule
